// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared defines for the MEM pipeline stage
// Holds the memory aluop codes, FSM state encoding, reset level and op decode helpers.
package mem_access_pkg;

    localparam logic RstEnable = 1'b0;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        MOP_NONE = 3'd0,
        MOP_LW   = 3'd1,
        MOP_LB   = 3'd2,
        MOP_LBU  = 3'd3,
        MOP_SW   = 3'd4,
        MOP_SB   = 3'd5
    } mem_op_e;

    function automatic mem_op_e decode_op(input logic [7:0] aluop);
        case (aluop)
            EXE_LW_OP:  return MOP_LW;
            EXE_LB_OP:  return MOP_LB;
            EXE_LBU_OP: return MOP_LBU;
            EXE_SW_OP:  return MOP_SW;
            EXE_SB_OP:  return MOP_SB;
            default:    return MOP_NONE;
        endcase
    endfunction

    function automatic logic is_load(input mem_op_e op);
        return (op == MOP_LW) || (op == MOP_LB) || (op == MOP_LBU);
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == MOP_SW) || (op == MOP_SB);
    endfunction

    function automatic logic is_word(input mem_op_e op);
        return (op == MOP_LW) || (op == MOP_SW);
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data memory bus between the MEM stage and memory
// master is the MEM stage side, slave is the memory side.
interface mem_access_if;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    modport master (
        output mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    modport slave (
        input  mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );
endinterface

// File: rtl/mem_lane_fmt.sv
// rtl/mem_lane_fmt.sv - little-endian byte-lane formatting for loads and stores
// Pure combinational: lane select, store byte replication, load sign/zero extension.
module mem_lane_fmt
    import mem_access_pkg::*;
(
    input  mem_op_e     i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_data,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0] w_byte;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_load_data[7:0];
            2'd1:    w_byte = i_load_data[15:8];
            2'd2:    w_byte = i_load_data[23:16];
            default: w_byte = i_load_data[31:24];
        endcase
    end

    always_comb begin
        o_sel   = is_word(i_op) ? 4'b1111 : 4'(4'b0001 << i_addr_lo);
        o_wdata = (i_op == MOP_SB) ? {4{i_store_data[7:0]}} : i_store_data;
        case (i_op)
            MOP_LW:  o_rdata = i_load_data;
            MOP_LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
            MOP_LBU: o_rdata = {24'd0, w_byte};
            default: o_rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage with stalling bus FSM and bus timeout
// Optional MEM_ALIGN_CHECK_EN: misaligned LW/SW skip the bus and raise adel_o/ades_o.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] store_data_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        buserr_o,
    output logic        adel_o,
    output logic        ades_o,
    mem_access_if.master bus
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      r_state;
    mem_op_e     r_op;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [4:0]  r_wd;
    logic [31:0] r_rdata;
    logic [7:0]  r_cnt;
    logic        r_timeout;
    logic        r_adel;
    logic        r_ades;

    mem_op_e     w_in_op;
    logic        w_misalign;
    logic [31:0] w_bus_addr;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;

    assign w_in_op = decode_op(aluop_i);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = is_word(w_in_op) && (mem_addr_i[1:0] != 2'b00);
    assign w_bus_addr = r_addr;
`else
    assign w_misalign = 1'b0;
    assign w_bus_addr = is_word(r_op) ? {r_addr[31:2], 2'b00} : r_addr;
`endif

    mem_lane_fmt u_lane_fmt (
        .i_op        (r_op),
        .i_addr_lo   (r_addr[1:0]),
        .i_store_data(r_sdata),
        .i_load_data (bus.mem_data_i),
        .o_sel       (w_sel),
        .o_wdata     (w_wdata),
        .o_rdata     (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_state   <= ST_IDLE;
            r_op      <= MOP_NONE;
            r_addr    <= 32'd0;
            r_sdata   <= 32'd0;
            r_wd      <= 5'd0;
            r_rdata   <= 32'd0;
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
            r_adel    <= 1'b0;
            r_ades    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timeout <= 1'b0;
                    r_adel    <= 1'b0;
                    r_ades    <= 1'b0;
                    if (w_in_op != MOP_NONE) begin
                        r_op    <= w_in_op;
                        r_addr  <= mem_addr_i;
                        r_sdata <= store_data_i;
                        r_wd    <= wd_i;
                        r_rdata <= 32'd0;
                        r_cnt   <= 8'd0;
                        if (w_misalign) begin
                            r_adel  <= is_load(w_in_op);
                            r_ades  <= is_store(w_in_op);
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_BUS;
                        end
                    end
                end
                // An ack in the limit cycle is checked first so it wins over the timeout.
                ST_BUS: begin
                    if (bus.mem_ack_i) begin
                        if (is_load(r_op)) begin
                            r_rdata <= w_rdata;
                        end
                        r_state <= ST_DONE;
                    end else if (r_cnt == TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wd_o            = 5'd0;
        wreg_o          = 1'b0;
        wdata_o         = 32'd0;
        stallreq_o      = 1'b0;
        buserr_o        = 1'b0;
        adel_o          = 1'b0;
        ades_o          = 1'b0;
        bus.mem_ce_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = 32'd0;
        bus.mem_sel_o   = 4'd0;
        bus.mem_data_o  = 32'd0;
        // The pass-through path is combinational, so it is gated explicitly during reset.
        if (rst != RstEnable) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_op == MOP_NONE) begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end else begin
                        stallreq_o = 1'b1;
                    end
                end
                ST_BUS: begin
                    stallreq_o     = 1'b1;
                    wd_o           = r_wd;
                    bus.mem_ce_o   = 1'b1;
                    bus.mem_we_o   = is_store(r_op);
                    bus.mem_addr_o = w_bus_addr;
                    bus.mem_sel_o  = w_sel;
                    bus.mem_data_o = w_wdata;
                end
                ST_DONE: begin
                    wd_o     = r_wd;
                    wreg_o   = is_load(r_op) && !r_timeout && !r_adel;
                    wdata_o  = r_rdata;
                    buserr_o = r_timeout;
                    adel_o   = r_adel;
                    ades_o   = r_ades;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 255, bus cycles allowed before abort (range 1..255).
REQ-002 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-low reset (RstEnable = 0).
REQ-004 SHALL have ports: aluop_i  in  8  EX-stage subtype; wd_i  in  5  destination register; wreg_i  in  1  write enable.
REQ-005 SHALL have ports: wdata_i  in  32  EX result; mem_addr_i  in  32  effective address; store_data_i  in  32  store operand.
REQ-006 SHALL have ports: wd_o  out  5; wreg_o  out  1; wdata_o  out  32 (to MEM-WB).
REQ-007 SHALL have ports: stallreq_o  out  1  freeze upstream pipeline.
REQ-008 SHALL have ports: buserr_o  out  1  one-cycle bus-timeout pulse; adel_o / ades_o  out  1  misaligned load/store pulses.
REQ-009 SHALL have ports: mem_ce_o  out  1; mem_we_o  out  1; mem_addr_o  out  32; mem_sel_o  out  4; mem_data_o  out  32; mem_data_i  in  32; mem_ack_i  in  1.

Function
REQ-010 Non-memory aluop SHALL pass wd_i/wreg_i/wdata_i to outputs combinationally, zero latency, stallreq_o=0.
REQ-011 Memory ops SHALL be LW, LB, LBU, SW, SB, decoded from aluop_i.
REQ-012 FSM states SHALL be IDLE, BUS, DONE.
REQ-013 IDLE: memory op present -> latch addr/data/op/wd into registers, go BUS; stallreq_o=1 same cycle.
REQ-014 BUS: mem_ce_o=1, bus outputs from latched registers and held stable until mem_ack_i=1; stallreq_o=1.
REQ-015 BUS with mem_ack_i=1: load data captured, go DONE; ack outside BUS SHALL be ignored.
REQ-016 DONE: stallreq_o=0; load -> wreg_o=1, wdata_o=captured result; store -> wreg_o=0; next state IDLE.
REQ-017 Memory-op latency SHALL be 2 cycles plus bus wait cycles (ack on first BUS cycle -> result in cycle 3).
REQ-018 Byte lanes little-endian: addr[1:0]=n -> mem_sel_o bit n; word -> 4'b1111.
REQ-019 LB SHALL sign-extend selected byte, LBU zero-extend; SB SHALL replicate byte on all four lanes.
REQ-020 Timeout counter SHALL clear on BUS entry, increment each BUS cycle without ack; reaching TIMEOUT_CYCLES -> DONE, wreg_o=0, buserr_o=1 for that DONE cycle.
REQ-021 Ack on the same cycle the counter reaches limit SHALL win (normal completion, no buserr_o).
REQ-022 Outside BUS, mem_ce_o=0 and mem_we_o=0.

Reset
REQ-023 rst=0 SHALL asynchronously force IDLE, counter 0, all latched registers 0.
REQ-024 During reset all outputs SHALL be 0 (including wd_o, wreg_o, wdata_o, stallreq_o, mem_*_o).
REQ-025 Reset asserted mid-BUS SHALL drop mem_ce_o immediately; no result written after release.

Configuration
REQ-026 Macro MEM_ALIGN_CHECK_EN defined: LW/SW with addr[1:0]!=0 SHALL skip BUS, go DONE, wreg_o=0, pulse adel_o (load) or ades_o (store).
REQ-027 Macro undefined: adel_o/ades_o tied 0; word access forces mem_addr_o[1:0]=0.

Structure
REQ-028 Memory aluop codes, FSM state encodings and RstEnable SHALL live in the shared defines file.
REQ-029 One sub-module, mem_lane_fmt (byte-lane select, store replication, load extension), combinational, is natural.

Verification
REQ-030 OR op, wdata_i=0x1234, wd_i=3, wreg_i=1 -> same cycle wdata_o=0x1234, wd_o=3, stallreq_o=0.
REQ-031 LW addr 0x100, ack on first BUS cycle, mem_data_i=0xDEADBEEF -> cycle 3 wdata_o=0xDEADBEEF, wreg_o=1, stallreq_o low in cycle 3.
REQ-032 LB addr 0x103, mem_data_i=0x80FF0000 -> mem_sel_o=4'b1000, wdata_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SB addr 0x2, store_data_i=0xAB -> mem_we_o=1, mem_sel_o=4'b0100, mem_data_o=0xABABABAB, wreg_o=0.
REQ-034 TIMEOUT_CYCLES=4, no ack -> 4 BUS cycles, then buserr_o=1 one cycle, wreg_o=0, back to IDLE.
REQ-035 With MEM_ALIGN_CHECK_EN, LW addr 0x101 -> mem_ce_o never 1, adel_o=1 one cycle; rst low mid-BUS -> mem_ce_o=0 immediately.
